// File: rtl/count_pkg.sv
// Shared state encoding and default sizing for the count sequence checker.
package count_pkg;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_CNT_W    = 8;
    localparam int unsigned DEF_SYNC_LEN = 2;
    // Wide enough for SYNC_LEN up to 15
    localparam int unsigned GOOD_W       = 4;

    typedef enum logic [1:0] {
        ST_SYNC0 = 2'd0,
        ST_SYNC  = 2'd1,
        ST_LOCK  = 2'd2
    } chk_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             ck,
    input  logic             res,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value
);

    localparam logic [CNT_W-1:0] MAX_VAL = '1;

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    // Next value: clear, else increment unless already at the ceiling
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != MAX_VAL)) begin
            value_d = value_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/count_checker.sv
// Protocol monitor for an up-counter bus: locks onto the sequence, flags
// illegal steps and counts errors and wrap-arounds.
module count_checker
    import count_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned SYNC_LEN = DEF_SYNC_LEN,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             ck,
    input  logic             res,
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             cnt_res,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0] exp_q
);

    // Value the observed counter should hold one edge after (v, e, cr) were applied
    function automatic logic [WIDTH-1:0] step_exp(input logic [WIDTH-1:0] v,
                                                  input logic e,
                                                  input logic cr);
        if (cr) return '0;
        if (e)  return v + WIDTH'(1);
        return v;
    endfunction

    chk_state_e        state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d, good_inc;
    logic [WIDTH-1:0]  prev_q_q;
    logic [WIDTH-1:0]  exp_nxt_q, exp_nxt_d;
    logic              en_d_q, cres_d_q;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic              wrap_q, wrap_d;
    logic [WIDTH-1:0]  exp_cur;
    logic              match;

    // Counter inputs act one edge late, so compare against the delayed copies
    assign exp_cur   = step_exp(prev_q_q, en_d_q, cres_d_q);
    assign match     = (q == exp_cur);
    assign good_inc  = good_q + GOOD_W'(1);
    assign exp_nxt_d = step_exp(q, en, cnt_res);

    // Next-state, lock tracking and pulse decode
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            ST_SYNC0: begin
                state_d = ST_SYNC;
                good_d  = '0;
            end
            ST_SYNC: begin
                if (match) begin
                    good_d = good_inc;
                    if (good_inc == GOOD_W'(SYNC_LEN)) state_d = ST_LOCK;
                end else begin
                    good_d = '0;
                end
            end
            ST_LOCK: begin
                if (!match) begin
                    err_d   = 1'b1;
                    state_d = ST_SYNC;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = ST_SYNC0;
                good_d  = '0;
            end
        endcase
        // A counter-reset return to zero is never a wrap
        if ((state_q != ST_SYNC0) && match && en_d_q && !cres_d_q &&
            (prev_q_q == '1) && (q == '0)) begin
            wrap_d = 1'b1;
        end
        locked_d = (state_d == ST_LOCK);
    end

    // State, history and registered outputs
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            state_q   <= ST_SYNC0;
            good_q    <= '0;
            prev_q_q  <= '0;
            en_d_q    <= 1'b0;
            cres_d_q  <= 1'b0;
            exp_nxt_q <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            prev_q_q  <= q;
            en_d_q    <= en;
            cres_d_q  <= cnt_res;
            exp_nxt_q <= exp_nxt_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            wrap_q    <= wrap_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .ck    (ck),
        .res   (res),
        .inc   (err_d),
        .clr   (clr),
        .value (err_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wrap_cnt (
        .ck    (ck),
        .res   (res),
        .inc   (wrap_d),
        .clr   (clr),
        .value (wrap_cnt)
    );

    assign locked = locked_q;
    assign err    = err_q;
    assign wrap   = wrap_q;
    assign exp_q  = exp_nxt_q;

endmodule

// File: tb/tb_count_checker.sv
// Randomized scoreboard bench: two checker instances (8-bit and 2-bit event
// counters) watch the same counter bus and are compared against a model.
module tb_count_checker;

    localparam int SL = 2;

    logic       ck = 1'b0;
    logic       res = 1'b0;
    logic [3:0] q = 4'd0;
    logic       en = 1'b0;
    logic       cnt_res = 1'b0;
    logic       clr = 1'b0;

    logic       locked8, err8, wrap8;
    logic [7:0] ec8, wc8;
    logic [3:0] exq8;
    logic       locked2, err2, wrap2;
    logic [1:0] ec2, wc2;
    logic [3:0] exq2;

    count_checker #(.WIDTH(4), .SYNC_LEN(SL), .CNT_W(8)) dut (
        .ck(ck), .res(res), .q(q), .en(en), .cnt_res(cnt_res), .clr(clr),
        .locked(locked8), .err(err8), .wrap(wrap8),
        .err_cnt(ec8), .wrap_cnt(wc8), .exp_q(exq8)
    );

    count_checker #(.WIDTH(4), .SYNC_LEN(SL), .CNT_W(2)) dut2 (
        .ck(ck), .res(res), .q(q), .en(en), .cnt_res(cnt_res), .clr(clr),
        .locked(locked2), .err(err2), .wrap(wrap2),
        .err_cnt(ec2), .wrap_cnt(wc2), .exp_q(exq2)
    );

    always #5 ck = ~ck;

    typedef struct packed {
        logic       locked;
        logic       err;
        logic       wrap;
        logic [7:0] ec8;
        logic [7:0] wc8;
        logic [1:0] ec2;
        logic [1:0] wc2;
        logic [3:0] exq;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: history of the last bus sample and lock bookkeeping
    bit         m_valid;
    int         h_q;
    bit         h_en, h_cres;
    bit         m_locked;
    int         m_streak;
    int         m_ec8, m_wc8, m_ec2, m_wc2;
    logic [3:0] cval = 4'd0;

    function automatic int sat_next(int cur, bit inc, bit cl, int maxv);
        if (cl) return 0;
        if (inc && cur < maxv) return cur + 1;
        return cur;
    endfunction

    task automatic model_reset();
        m_valid = 0; h_q = 0; h_en = 0; h_cres = 0;
        m_locked = 0; m_streak = 0;
        m_ec8 = 0; m_wc8 = 0; m_ec2 = 0; m_wc2 = 0;
    endtask

    // Outcome of one rising edge given the bus values present at that edge
    task automatic model_edge(input int qv, input bit e, input bit cr, input bit cl,
                              output exp_t x);
        bit m_err  = 0;
        bit m_wrap = 0;
        int expv;
        bit hit;
        if (!m_valid) begin
            m_valid  = 1;
            m_streak = 0;
            m_locked = 0;
        end else begin
            expv   = h_cres ? 0 : (h_en ? (h_q + 1) % 16 : h_q);
            hit    = (qv == expv);
            m_wrap = hit && h_en && !h_cres && (h_q == 15) && (qv == 0);
            if (m_locked) begin
                if (!hit) begin
                    m_err    = 1;
                    m_locked = 0;
                    m_streak = 0;
                end
            end else if (hit) begin
                m_streak++;
                if (m_streak >= SL) m_locked = 1;
            end else begin
                m_streak = 0;
            end
        end
        m_ec8 = sat_next(m_ec8, m_err, cl, 255);
        m_ec2 = sat_next(m_ec2, m_err, cl, 3);
        m_wc8 = sat_next(m_wc8, m_wrap, cl, 255);
        m_wc2 = sat_next(m_wc2, m_wrap, cl, 3);
        h_q = qv; h_en = e; h_cres = cr;
        x.locked = m_locked;
        x.err    = m_err;
        x.wrap   = m_wrap;
        x.ec8    = 8'(m_ec8);
        x.wc8    = 8'(m_wc8);
        x.ec2    = 2'(m_ec2);
        x.wc2    = 2'(m_wc2);
        x.exq    = cr ? 4'd0 : (e ? 4'((qv + 1) % 16) : 4'(qv));
    endtask

    // Present one bus sample for the next edge; the counter follows what was driven
    task automatic step(input logic [3:0] qv, input bit e, input bit cr, input bit cl);
        exp_t x;
        @(negedge ck);
        res = 1'b1; q = qv; en = e; cnt_res = cr; clr = cl;
        model_edge(int'(qv), e, cr, cl, x);
        sb.push_back(x);
        cval = cr ? 4'd0 : (e ? qv + 4'd1 : qv);
    endtask

    task automatic run(input int n);
        repeat (n) step(cval, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic hold_reset(input int n);
        repeat (n) begin
            @(negedge ck);
            res = 1'b0;
            model_reset();
            sb.push_back('0);
        end
    endtask

    // Run freely until the model is locked and the counter shows `target` (-1 = any)
    task automatic seek(input int target);
        int i = 0;
        while (!(m_locked && (target < 0 || int'(cval) == target)) && i < 64) begin
            run(1);
            i++;
        end
        if (i >= 64) begin
            vectors++;
            miscompares++;
            $display("FAIL seek: no lock at q=%0d within 64 cycles, locked=%0b", target, m_locked);
        end
    endtask

    // Reset asserted between edges must clear outputs without a clock edge
    task automatic async_reset();
        @(negedge ck);
        #2 res = 1'b0;
        #1;
        vectors++;
        if ({locked8, err8, wrap8, ec8, wc8, exq8, locked2, err2, wrap2, ec2, wc2, exq2} != '0) begin
            miscompares++;
            $display("FAIL async_reset: got locked=%0b err_cnt=%0d wrap_cnt=%0d (cnt2 %0d/%0d), need all 0",
                     locked8, ec8, wc8, ec2, wc2);
        end
        model_reset();
        sb.push_back('0);
    endtask

    // Monitor: compare both instances against the queued expectation every edge
    initial begin
        exp_t x;
        exp_t g8;
        exp_t g2;
        forever begin
            @(posedge ck);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                g8 = x; g2 = x;
                g8.locked = locked8; g8.err = err8; g8.wrap = wrap8;
                g8.ec8 = ec8; g8.wc8 = wc8; g8.exq = exq8;
                g2.locked = locked2; g2.err = err2; g2.wrap = wrap2;
                g2.ec2 = ec2; g2.wc2 = wc2; g2.exq = exq2;
                vectors++;
                if (g8 != x || g2 != x) begin
                    miscompares++;
                    $display("FAIL edge t=%0t: got8 L%0b E%0b W%0b ec%0d wc%0d x%0d | got2 L%0b E%0b W%0b ec%0d wc%0d x%0d | need L%0b E%0b W%0b ec%0d/%0d wc%0d/%0d x%0d",
                             $time, locked8, err8, wrap8, ec8, wc8, exq8,
                             locked2, err2, wrap2, ec2, wc2, exq2,
                             x.locked, x.err, x.wrap, x.ec8, x.ec2, x.wc8, x.wc2, x.exq);
                end
            end
        end
    end

    initial begin
        bit e, cr, cl;
        logic [3:0] qv;
        model_reset();
        hold_reset(2);

        // Free-running count: lock acquisition and repeated wraps
        run(40);

        // Illegal jump 5 -> 7 while locked, then re-acquire
        seek(5);
        step(4'd7, 1'b1, 1'b0, 1'b0);
        run(6);

        // Counter reset at 9: the following 0 is legal and not a wrap
        seek(9);
        step(4'd9, 1'b1, 1'b1, 1'b0);
        run(5);

        // Enable low with q held at 3, then an illegal change while held
        seek(3);
        repeat (4) step(4'd3, 1'b0, 1'b0, 1'b0);
        step(4'd4, 1'b0, 1'b0, 1'b0);
        run(6);

        // Five locked errors drive the narrow counter into saturation
        repeat (5) begin
            seek(-1);
            step(cval + 4'd3, 1'b1, 1'b0, 1'b0);
        end
        // Clear together with a sixth error
        seek(-1);
        step(cval + 4'd3, 1'b1, 1'b0, 1'b1);
        run(4);

        // Randomized traffic with occasional glitches, counter resets and clears
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                async_reset();
            end
            e  = ($urandom_range(0, 99) < 80);
            cr = ($urandom_range(0, 19) == 0);
            cl = ($urandom_range(0, 29) == 0);
            qv = cval;
            if ($urandom_range(0, 14) == 0) qv = cval ^ 4'($urandom_range(1, 15));
            step(qv, e, cr, cl);
        end

        // Reset in the middle of LOCK, then re-acquire
        seek(-1);
        async_reset();
        run(10);

        @(negedge ck);
        @(negedge ck);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, need 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
